// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int INSTR_BYTES  = 4;

  // Clears the byte-offset bits so every fetch address is instruction aligned.
  localparam logic [FETCH_ADDR_W-1:0] ALIGN_MASK = ~FETCH_ADDR_W'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] target;
    logic                    misaligned;
  } redirect_t;

  // PC-relative target; the sum wraps modulo 2^ADDR_W before alignment.
  function automatic redirect_t compute_target(input logic [FETCH_ADDR_W-1:0] base,
                                               input logic [FETCH_ADDR_W-1:0] offset);
    logic [FETCH_ADDR_W-1:0] raw;
    redirect_t               res;
    raw            = base + offset;
    res.target     = raw & ALIGN_MASK;
    res.misaligned = |(raw & ~ALIGN_MASK);
    return res;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over sequential increment.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  // Next PC: redirect load beats increment; otherwise hold.
  always_comb begin
    // NOTE: default first so every path assigns pc_d and no latch is inferred.
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  // PC state, cleared asynchronously to the reset address.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!reset) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, holds the
// returned instruction for decode and applies squashing PC-relative redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter int                DATA_W     = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] redirect_offset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              misaligned
);

  state_e            state_q, state_d;
  logic              squash_q, squash_d;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_q, pc_next;
  redirect_t         rd;

  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              misaligned_q, misaligned_d;
  logic              capture;

  assign rd = compute_target(redirect_pc, redirect_offset);

  pc_reg #(
    .ADDR_W    (ADDR_W),
    .RESET_ADDR(RESET_ADDR)
  ) u_pc_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (pc_load),
    .load_value(rd.target),
    .inc       (pc_inc),
    .pc        (pc_q)
  );

  // PC value after this edge, used as the address of a newly started request.
  always_comb begin
    pc_next = pc_q;
    if (pc_load) begin
      pc_next = rd.target;
    end else if (pc_inc) begin
      pc_next = pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  // State and squash registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  // Next-state logic; redirect outranks response and decode handshake.
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pc_load = redirect_valid;
        if (!halt) state_d = S_REQ;
      end
      S_REQ: begin
        // The issued address stays on the bus; its data will be dropped.
        if (redirect_valid) begin
          pc_load  = 1'b1;
          squash_d = 1'b1;
        end
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        pc_load = redirect_valid;
        if (imem_resp_valid) begin
          if (squash_q || redirect_valid) begin
            squash_d = 1'b0;
            state_d  = halt ? S_IDLE : S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          state_d = halt ? S_IDLE : S_REQ;
        end else if (instr_ready) begin
          pc_inc  = 1'b1;
          state_d = halt ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values, derived from the state transition.
  always_comb begin
    capture       = (state_q == S_WAIT) && (state_d == S_HOLD);
    req_valid_d   = (state_d == S_REQ);
    req_addr_d    = ((state_d == S_REQ) && (state_q != S_REQ)) ? pc_next : req_addr_q;
    instr_valid_d = (state_d == S_HOLD);
    instr_data_d  = capture ? imem_resp_data : instr_data_q;
    instr_pc_d    = capture ? pc_q : instr_pc_q;
    misaligned_d  = redirect_valid && rd.misaligned;
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_valid_q   <= 1'b0;
      req_addr_q    <= RESET_ADDR;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_pc_q    <= RESET_ADDR;
      misaligned_q  <= 1'b0;
    end else begin
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      instr_pc_q    <= instr_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = instr_valid_q;
  assign instr_data     = instr_data_q;
  assign instr_pc       = instr_pc_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each step drives inputs #1 after a
// rising edge and checks the registered outputs produced by that edge.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_offset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_offset(redirect_offset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .misaligned     (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"},   32'(imem_req_valid), 32'd0);
    check({tag, "_req_addr"},    imem_req_addr,       32'h0);
    check({tag, "_instr_valid"}, 32'(instr_valid),    32'd0);
    check({tag, "_instr_data"},  instr_data,          32'h0);
    check({tag, "_instr_pc"},    instr_pc,            32'h0);
    check({tag, "_misaligned"},  32'(misaligned),     32'd0);
  endtask

  initial begin
    reset           = 1'b0;
    halt            = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    redirect_offset = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    instr_ready     = 1'b0;

    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b1;

    // First request one cycle after release, held under back-pressure.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_req_valid", 32'(imem_req_valid), 32'd1);
      check("bp_req_addr",  imem_req_addr,       32'h0);
    end
    imem_req_ready = 1'b1;
    tick();
    check("acc_req_valid", 32'(imem_req_valid), 32'd0);
    imem_req_ready = 1'b0;
    tick();
    check("wait_instr_valid", 32'(instr_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hA5A5_0001;
    tick();
    imem_resp_valid = 1'b0;
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_data",  instr_data,       32'hA5A5_0001);
    check("hold_pc",    instr_pc,         32'h0);

    // Decode stalls: instruction and its PC must stay put, no new request.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid",     32'(instr_valid),    32'd1);
      check("stall_data",      instr_data,          32'hA5A5_0001);
      check("stall_pc",        instr_pc,            32'h0);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("inc_req_valid",   32'(imem_req_valid), 32'd1);
    check("inc_req_addr",    imem_req_addr,       32'h4);
    check("inc_instr_valid", 32'(instr_valid),    32'd0);

    // Free-flowing fetch of 0x4 with memory always ready.
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hA5A5_0002;
    tick();
    imem_resp_valid = 1'b0;
    check("f2_valid", 32'(instr_valid), 32'd1);
    check("f2_pc",    instr_pc,         32'h4);
    check("f2_data",  instr_data,       32'hA5A5_0002);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("f3_req_addr",    imem_req_addr,    32'h8);
    check("f3_instr_valid", 32'(instr_valid), 32'd0);

    // Redirect while waiting: 0x10 + (-8) = 0x8, pending data is dropped.
    tick();
    imem_req_ready  = 1'b0;
    check("w_req_valid", 32'(imem_req_valid), 32'd0);
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h10;
    redirect_offset = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("rw_misaligned",  32'(misaligned),  32'd0);
    check("rw_instr_valid", 32'(instr_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0003;
    tick();
    imem_resp_valid = 1'b0;
    check("sq_instr_valid", 32'(instr_valid),    32'd0);
    check("sq_req_valid",   32'(imem_req_valid), 32'd1);
    check("sq_req_addr",    imem_req_addr,       32'h8);

    // Redirect in hold coinciding with decode accept: 0x4 + 0x102 = 0x106.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hA5A5_0004;
    tick();
    imem_resp_valid = 1'b0;
    check("h4_valid", 32'(instr_valid), 32'd1);
    check("h4_pc",    instr_pc,         32'h8);
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h4;
    redirect_offset = 32'h102;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    check("rh_misaligned",  32'(misaligned),     32'd1);
    check("rh_instr_valid", 32'(instr_valid),    32'd0);
    check("rh_req_valid",   32'(imem_req_valid), 32'd1);
    check("rh_req_addr",    imem_req_addr,       32'h104);
    tick();
    check("rh_mis_pulse", 32'(misaligned), 32'd0);
    check("rh_addr_hold", imem_req_addr,   32'h104);

    // Redirect together with a response, landing on the top word.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'hFFFF_FFF0;
    redirect_offset = 32'hC;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0005;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    check("rr_instr_valid", 32'(instr_valid), 32'd0);
    check("rr_req_addr",    imem_req_addr,    32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hA5A5_0006;
    tick();
    imem_resp_valid = 1'b0;
    check("top_pc",   instr_pc,   32'hFFFF_FFFC);
    check("top_data", instr_data, 32'hA5A5_0006);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_req_addr",  imem_req_addr,       32'h0);

    // Halt lets the issued request and held instruction finish, then idles.
    halt           = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("halt_acc", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hA5A5_0007;
    tick();
    imem_resp_valid = 1'b0;
    check("halt_hold_valid", 32'(instr_valid), 32'd1);
    check("halt_hold_data",  instr_data,       32'hA5A5_0007);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("halt_idle_valid", 32'(instr_valid),    32'd0);
    check("halt_idle_req",   32'(imem_req_valid), 32'd0);
    tick();
    check("halt_idle_req2", 32'(imem_req_valid), 32'd0);
    halt = 1'b0;
    tick();
    check("unhalt_req_valid", 32'(imem_req_valid), 32'd1);
    check("unhalt_req_addr",  imem_req_addr,       32'h4);

    // Reset asserted while waiting; a late response must be ignored.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_values("mid_rst");
    tick();
    reset           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0008;
    tick();
    imem_resp_valid = 1'b0;
    check("post_rst_instr_valid", 32'(instr_valid),    32'd0);
    check("post_rst_req_valid",   32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr",    imem_req_addr,       32'h0);
    tick();
    check("post_rst_instr_valid2", 32'(instr_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns the program counter and sequences instruction fetch.
- Issues one request at a time to instruction memory over a valid/ready handshake.
- Holds each returned instruction until decode accepts it.
- Applies PC-relative redirects (branches/jumps), squashing any in-flight fetch. Sits between the PC/branch logic and the decode stage.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- INSTR_BYTES, 4, sequential PC increment.
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- halt  in  1  when 1, no new fetch request is started.
- redirect_valid  in  1  single-cycle redirect strobe.
- redirect_pc  in  ADDR_W  PC of the redirecting instruction.
- redirect_offset  in  ADDR_W  signed byte offset added to redirect_pc.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch address.
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  fetch data valid, 1-cycle pulse.
- imem_resp_data  in  DATA_W  fetched instruction.
- instr_valid  out  1  instruction available to decode.
- instr_data  out  DATA_W  held instruction.
- instr_pc  out  ADDR_W  address of the held instruction.
- instr_ready  in  1  decode accepts the instruction.
- misaligned  out  1  1-cycle pulse when a redirect target has nonzero low 2 bits.

Behaviour:
- All outputs are registered. While reset=0:
  - state=S_IDLE, pc=RESET_ADDR, squash=0.
  - imem_req_valid=0, imem_req_addr=RESET_ADDR.
  - instr_valid=0, instr_data=0, instr_pc=RESET_ADDR, misaligned=0.
- Redirect target = (redirect_pc + redirect_offset) mod 2^32, with bits[1:0] forced to 0. misaligned pulses the cycle after a redirect whose raw target has nonzero bits[1:0].
- Only one request is outstanding at a time.
- S_IDLE:
  - If halt=0, go to S_REQ next cycle with imem_req_valid=1 and imem_req_addr=pc. The first request therefore appears 1 cycle after reset release.
  - A redirect here loads pc=target and stays in S_IDLE if halt=1.
- S_REQ:
  - imem_req_valid and imem_req_addr stay stable until imem_req_ready=1.
  - On acceptance, drop valid and go to S_WAIT.
  - A redirect in S_REQ loads pc=target, leaves the request address unchanged, and sets squash=1. If the redirect coincides with acceptance, squash is still set.
- S_WAIT:
  - On imem_resp_valid with squash=0 and no redirect: capture instr_data and instr_pc=pc, set instr_valid=1, go to S_HOLD.
  - On imem_resp_valid with squash=1, or with redirect_valid in the same cycle: discard the data, clear squash, load pc=target if redirecting, and go to S_REQ (or S_IDLE if halt=1).
  - A redirect without a response loads pc=target, sets squash=1, and stays in S_WAIT.
- S_HOLD:
  - instr_valid=1; data and pc are stable until instr_ready=1.
  - On instr_ready=1: pc=pc+INSTR_BYTES (wraps 32'hFFFF_FFFC -> 0), clear instr_valid, go to S_REQ (S_IDLE if halt=1).
  - On redirect_valid: clear instr_valid and set pc=target, ignoring the increment. This applies even if instr_ready=1 in the same cycle, in which case decode is considered to have consumed the instruction. Then go to S_REQ/S_IDLE.
- halt never aborts an issued request or a held instruction. It only blocks the S_IDLE->S_REQ transition and the return to S_REQ.
- Reset asserted mid-operation returns immediately to reset values. Responses arriving after reset release but before a new request are ignored, because S_IDLE ignores imem_resp_valid.
- Priority within a cycle: reset > redirect > response/handshake > increment.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (S_IDLE, S_REQ, S_WAIT, S_HOLD);
  - INSTR_BYTES;
  - alignment mask constant;
  - target-compute function.
- One natural sub-module: pc_reg, which holds pc and applies load/increment with async active-low reset to RESET_ADDR. The FSM stays in fetch_sequencer.

Test Plan:
1. Reset release, imem_req_ready=1, response 2 cycles later with data 32'hA5A5_0001, instr_ready=1 -> requests at 0x0, 0x4, 0x8; instr_pc 0x0, 0x4 in order; instr_valid one cycle per instruction.
2. Back-pressure: imem_req_ready=0 for 3 cycles -> imem_req_valid=1 with addr 0x0 stable all 3 cycles. instr_ready=0 for 4 cycles -> instr_data/instr_pc stable, pc not incremented.
3. Redirect in S_WAIT with redirect_pc=0x10, offset=-8 -> pending response discarded, instr_valid stays 0, next request addr 0x8.
4. Redirect in S_HOLD coincident with instr_ready, redirect_pc=0x4, offset=0x102 -> misaligned pulses 1 cycle, next request addr 0x104, no 0x8 fetch.
5. pc=32'hFFFF_FFFC accepted -> next request addr 0x0.
6. reset dropped while in S_WAIT, then imem_resp_valid pulse -> no instr_valid, outputs at reset values, first request addr RESET_ADDR one cycle after release.
